// File: rtl/penc_pkg.sv
// rtl/penc_pkg.sv - shared constants for the priority encoder / arbiter
package penc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/penc_search.sv
// rtl/penc_search.sv - combinational winner search: highest-set (fixed) or
// first-set upward from start with wraparound (round-robin)
module penc_search
  import penc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         found,
  output logic         multi
);

  function automatic logic [W-1:0] rr_pos(input logic [W-1:0] s, input int k);
    int p;
    p = int'(s) + k;
    if (p >= N) p = p - N;
    return W'(p);
  endfunction

  // Later loop iterations overwrite earlier ones, so the last hit wins.
  always_comb begin
    idx = '0;
    if (mode == MODE_FIXED) begin
      for (int k = 0; k < N; k++) begin
        if (req[k]) idx = W'(k);
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req[rr_pos(start, k)]) idx = rr_pos(start, k);
      end
    end
  end

  assign found = |req;
  assign multi = |(req & (req - {{(N-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/penc_arb.sv
// rtl/penc_arb.sv - N-input priority encoder / arbiter with a one-entry
// valid/ready output register and round-robin pointer
module penc_arb
  import penc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_multi
);

  logic [W-1:0] ptr;
  logic [W-1:0] win_idx;
  logic         found;
  logic         multi;
  logic         slot_free;
  logic         capture;
  logic [W:0]   win_inc;
  logic [W-1:0] ptr_nxt;

  penc_search #(.N(N)) u_search (
    .req   (req),
    .start (ptr),
    .mode  (mode),
    .idx   (win_idx),
    .found (found),
    .multi (multi)
  );

  assign slot_free = !out_valid || out_ready;
  assign capture   = slot_free && en && found;

  // Widened by one bit so winner+1 cannot alias to 0 before the compare.
  assign win_inc = {1'b0, win_idx} + {{W{1'b0}}, 1'b1};
  assign ptr_nxt = (win_inc == (W + 1)'(N)) ? '0 : win_inc[W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_multi <= 1'b0;
      ptr       <= '0;
    end else if (slot_free) begin
      if (capture) begin
        out_idx   <= win_idx;
        out_valid <= 1'b1;
        out_multi <= multi;
        if (mode == MODE_RR) ptr <= ptr_nxt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_penc_arb.sv
// tb/tb_penc_arb.sv - bench for penc_arb with N=8 and N=5 instances
module tb_penc_arb;
  import penc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en8, mode8, rdy8, v8, m8;
  logic [7:0] req8;
  logic [2:0] idx8;
  logic       en5, mode5, rdy5, v5, m5;
  logic [4:0] req5;
  logic [2:0] idx5;

  int total = 0;
  int bad   = 0;
  int mv[2], mi[2], mm[2], mp[2];

  always #5 clk = ~clk;

  penc_arb #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .mode(mode8), .req(req8),
    .out_idx(idx8), .out_valid(v8), .out_ready(rdy8), .out_multi(m8)
  );

  penc_arb #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .en(en5), .mode(mode5), .req(req5),
    .out_idx(idx5), .out_valid(v5), .out_ready(rdy5), .out_multi(m5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      mv[u] = 0; mi[u] = 0; mm[u] = 0; mp[u] = 0;
    end
  endtask

  // Reference: behaviour stated as rules over integers, one call per clock edge.
  task automatic model(input int u, input bit e, input bit md, input int rq, input bit rd);
    int n;
    int cnt;
    int w;
    bit fnd;
    n = (u == 0) ? 8 : 5;
    cnt = 0; w = 0; fnd = 0;
    if (mv[u] != 0 && !rd) return;
    if (!e || rq == 0) begin
      mv[u] = 0;
      return;
    end
    for (int k = 0; k < n; k++) if (rq[k]) cnt++;
    if (md == MODE_FIXED) begin
      for (int k = n - 1; k >= 0; k--)
        if (rq[k] && !fnd) begin w = k; fnd = 1; end
    end else begin
      for (int k = 0; k < n; k++)
        if (rq[(mp[u] + k) % n] && !fnd) begin w = (mp[u] + k) % n; fnd = 1; end
      mp[u] = (w + 1) % n;
    end
    mv[u] = 1;
    mi[u] = w;
    mm[u] = (cnt > 1) ? 1 : 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".v8"},   32'(v8),        32'(mv[0]));
    chk({tag, ".p8"},   32'(dut8.ptr),  32'(mp[0]));
    chk({tag, ".v5"},   32'(v5),        32'(mv[1]));
    chk({tag, ".p5"},   32'(dut5.ptr),  32'(mp[1]));
    if (mv[0] != 0) begin
      chk({tag, ".i8"}, 32'(idx8), 32'(mi[0]));
      chk({tag, ".m8"}, 32'(m8),   32'(mm[0]));
    end
    if (mv[1] != 0) begin
      chk({tag, ".i5"}, 32'(idx5), 32'(mi[1]));
      chk({tag, ".m5"}, 32'(m5),   32'(mm[1]));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model(0, en8, mode8, int'(req8), rdy8);
    model(1, en5, mode5, int'(req5), rdy5);
    #1;
    chk_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    en8 = 0; mode8 = MODE_FIXED; rdy8 = 0; req8 = '0;
    en5 = 0; mode5 = MODE_FIXED; rdy5 = 0; req5 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.v8", 32'(v8), 0);
    chk("reset.i8", 32'(idx8), 0);
    chk("reset.m8", 32'(m8), 0);
    rst = 1'b0;

    // fixed priority
    en8 = 1; mode8 = MODE_FIXED; rdy8 = 1; req8 = 8'b0010_0100;
    tick("fixed1");
    chk("fixed1.idx", 32'(idx8), 5);
    chk("fixed1.multi", 32'(m8), 1);
    req8 = 8'b0000_0001;
    tick("fixed2");
    chk("fixed2.idx", 32'(idx8), 0);
    chk("fixed2.multi", 32'(m8), 0);

    // async reset while FULL holding index 5
    req8 = 8'b0010_0000;
    tick("prerst");
    chk("prerst.idx", 32'(idx8), 5);
    rdy8 = 0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst.v8", 32'(v8), 0);
    chk("arst.i8", 32'(idx8), 0);
    chk("arst.m8", 32'(m8), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all("arst");

    // round-robin fairness from reset
    mode8 = MODE_RR; req8 = 8'hFF; rdy8 = 1;
    for (int i = 0; i < 10; i++) begin
      tick("rr");
      chk("rr.idx", 32'(idx8), 32'(i % 8));
      chk("rr.valid", 32'(v8), 1);
    end
    tick("rr2");
    tick("rr3");
    chk("bp.start", 32'(idx8), 3);

    // backpressure
    rdy8 = 0;
    for (int i = 0; i < 4; i++) begin
      req8 = 8'($urandom);
      tick("bp");
      chk("bp.idx", 32'(idx8), 3);
      chk("bp.ptr", 32'(dut8.ptr), 4);
    end
    rdy8 = 1; req8 = 8'b0001_0001;
    tick("bp.rel");
    chk("bp.next", 32'(idx8), 4);

    // idle and enable
    req8 = 8'h00;
    tick("idle");
    chk("idle.valid", 32'(v8), 0);
    chk("idle.ptr", 32'(dut8.ptr), 5);
    req8 = 8'hFF;
    tick("reload");
    en8 = 0;
    tick("en0");
    chk("en0.valid", 32'(v8), 0);
    chk("en0.ptr", 32'(dut8.ptr), 6);

    // N=5 wrap
    en5 = 1; mode5 = MODE_RR; rdy5 = 1; req5 = 5'b10000;
    tick("w5a");
    chk("w5a.idx", 32'(idx5), 4);
    chk("w5a.ptr", 32'(dut5.ptr), 0);
    req5 = 5'b10010;
    tick("w5b");
    chk("w5b.idx", 32'(idx5), 1);
    chk("w5b.ptr", 32'(dut5.ptr), 2);
    req5 = 5'b00001;
    tick("w5c");
    chk("w5c.idx", 32'(idx5), 0);

    // randomized
    for (int i = 0; i < 400; i++) begin
      en8 = ($urandom_range(0, 7) != 0); mode8 = 1'($urandom);
      rdy8 = ($urandom_range(0, 3) != 0); req8 = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      en5 = ($urandom_range(0, 7) != 0); mode5 = 1'($urandom);
      rdy5 = ($urandom_range(0, 3) != 0); req5 = ($urandom_range(0, 5) == 0) ? 5'h00 : 5'($urandom);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/penc_arb.md
# penc_arb

Parametrised N-input priority encoder with a registered, handshaked output and selectable fixed-priority or round-robin arbitration. It generalises the combinational 8:3 encoder to any width and adds three things: defined behaviour for multi-hot inputs, fairness across requesters, and a one-entry output register with valid/ready flow control. It sits between a bank of request lines and a single downstream consumer of encoded indices.

## Interface
Parameters:
- N, 8: number of request lines; N ≥ 2.
- W, $clog2(N): index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  capture enable; when 0, no new request is encoded.
- mode  in  1  0 = fixed priority, highest index wins; 1 = round-robin.
- req  in  N  request vector; any number of bits may be set.
- out_idx  out  W  encoded index of the granted request.
- out_valid  out  1  out_idx/out_multi hold a grant not yet accepted.
- out_ready  in  1  consumer accepts the grant when out_valid && out_ready.
- out_multi  out  1  more than one req bit was set at capture.

## Operation
- State: output register {out_idx, out_valid, out_multi} and round-robin pointer ptr[W-1:0].
- Implicit two-state machine keyed on out_valid:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- slot_free = !out_valid || out_ready.
- capture = slot_free && en && (req != 0).
- On capture:
  - out_idx ← winner.
  - out_valid ← 1.
  - out_multi ← (popcount(req) > 1).
- On slot_free && !capture: out_valid ← 0. out_idx and out_multi keep their last values.
- While FULL && !out_ready: all outputs hold. req, en and mode are ignored.
- Winner selection:
  - mode 0: highest set index of req.
  - mode 1: first set index searching upward from ptr, wrapping N-1 → 0.
- ptr update:
  - Only on capture in mode 1: ptr ← (winner + 1) mod N, with a true modulo for non-power-of-2 N.
  - Unchanged in mode 0.
  - Retained across mode switches.
- Single-bit req gives the same index in both modes (one-hot encoding as before).
- req = 0 never produces a grant. No "index 0" ambiguity: out_valid qualifies out_idx.

## Timing
- Reset (asynchronous, immediate): out_idx = 0, out_valid = 0, out_multi = 0, ptr = 0.
- Reset asserted mid-transfer: the pending grant is dropped, with no acceptance implied.
- Latency: req sampled at edge k appears on outputs after edge k; one cycle.
- Throughput: one grant per cycle when out_ready is held at 1. Accept and a new capture occur on the same edge.
- Simultaneous accept with no new capture: out_valid falls on that edge.
- mode and en are sampled on the capture edge only.
- Outputs are pure register outputs; there is no combinational path from req or out_ready to outputs.

## Structure
- Shared package penc_pkg holds MODE_FIXED = 1'b0 and MODE_RR = 1'b1, used by this block and its bench.
- Sub-module penc_search: combinational, parameter N. Inputs req and start; outputs idx, found and multi.
  - Fixed mode is served by start = 0 with a reversed-priority path, or by a separate highest-set search inside the same sub-module selected by mode.
- Top level contains only the output register, ptr and handshake logic. Target is roughly 150–250 lines in total.

## Test plan
- Reset: drive rst = 1 while FULL with out_idx = 5 → out_valid = 0, out_idx = 0, out_multi = 0 with no clock edge; ptr = 0 afterwards.
- Fixed priority: N = 8, mode = 0, en = 1, out_ready = 1, req = 8'b0010_0100 → next cycle out_valid = 1, out_idx = 5, out_multi = 1. Then req = 8'b0000_0001 → out_idx = 0, out_multi = 0.
- Round-robin fairness: mode = 1, req = 8'hFF held, out_ready = 1 from reset → out_idx sequence is 0,1,2,…,7,0,1 on consecutive cycles, with out_valid continuously 1.
- Backpressure: FULL with out_idx = 3 and out_ready = 0 for 4 cycles while req toggles → out_idx stays 3 and ptr stays 4. On out_ready = 1 with req = 8'b0001_0001, the next grant is 4.
- Idle and enable: req = 0, or en = 0 with req = 8'hFF, after an accepted grant → out_valid = 0 on the next edge and ptr is unchanged.
- Wrap with N = 5: mode = 1, grant idx 4 (ptr wraps to 0), then req = 5'b10010 → out_idx = 1. Then ptr = 2 and req = 5'b00001 → out_idx = 0.
